// File: rtl/string_match_pkg.sv
// string_match_pkg: shared constants, controller states and flagged-string type
package string_match_pkg;
  localparam int MAX_STRLEN = 17;
  localparam logic [4:0] LEN_ADDR = 5'd31;
  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, REPORT, CLEAR} ctrl_state_t;
  typedef logic [0:16][7:0] flag_str_t;
endpackage

// File: rtl/string_slot_regs.sv
// string_slot_regs: per-slot flagged string/length registers, write decode and prog_err pulse
module string_slot_regs
  import string_match_pkg::*;
#(
  parameter int NUM_SLOTS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prog_we,
  input  logic                     prog_ready,
  input  logic [2:0]               prog_slot,
  input  logic [4:0]               prog_addr,
  input  logic [7:0]               prog_data,
  output logic                     prog_err,
  output logic [NUM_SLOTS*136-1:0] cmp_flagged_string,
  output logic [NUM_SLOTS*5-1:0]   cmp_strlen,
  output logic [NUM_SLOTS-1:0]     slot_en
`ifdef STRING_MATCH_HITCNT_EN
  ,
  output logic [NUM_SLOTS-1:0]     len_wr
`endif
);
  flag_str_t  str_q [NUM_SLOTS];
  logic [4:0] len_q [NUM_SLOTS];
  logic       byte_ok, len_ok, ok;
  always_comb begin
    byte_ok = prog_addr < 5'(MAX_STRLEN);
    len_ok  = prog_addr == LEN_ADDR && prog_data[4:0] <= 5'(MAX_STRLEN);
    ok      = prog_we && prog_ready && int'(prog_slot) < NUM_SLOTS && (byte_ok || len_ok);
  end
  always_ff @(posedge clk) begin
    prog_err <= !rst && prog_we && !ok;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (rst) begin
        str_q[i] <= '0;
        len_q[i] <= '0;
      end else if (ok && prog_slot == 3'(i)) begin
        if (len_ok) len_q[i] <= prog_data[4:0];
        else str_q[i][prog_addr] <= prog_data;
      end
  end
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_out
    assign cmp_flagged_string[g*136 +: 136] = str_q[g];
    assign cmp_strlen[g*5 +: 5]             = len_q[g];
    assign slot_en[g]                       = |len_q[g];
`ifdef STRING_MATCH_HITCNT_EN
    assign len_wr[g] = ok && len_ok && prog_slot == 3'(g);
`endif
  end
endmodule

// File: rtl/string_match_ctrl.sv
// string_match_ctrl: comparator bank sequencer and per-frame verdict (STRING_MATCH_HITCNT_EN adds per-slot hit counters)
module string_match_ctrl
  import string_match_pkg::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prog_we,
  input  logic [2:0]               prog_slot,
  input  logic [4:0]               prog_addr,
  input  logic [7:0]               prog_data,
  output logic                     prog_ready,
  output logic                     prog_err,
  input  logic                     frame_start,
  input  logic                     frame_end,
  output logic                     cmp_clear,
  output logic [NUM_SLOTS*136-1:0] cmp_flagged_string,
  output logic [NUM_SLOTS*5-1:0]   cmp_strlen,
  input  logic [NUM_SLOTS-1:0]     cmp_match,
  output logic                     result_valid,
  output logic                     result_hit,
  output logic [NUM_SLOTS-1:0]     result_mask,
  input  logic                     result_ack,
  output logic [7:0]               drop_cnt
`ifdef STRING_MATCH_HITCNT_EN
  ,
  input  logic [2:0]               hitcnt_sel,
  output logic [15:0]              hitcnt_data
`endif
);
  ctrl_state_t          state, nxt;
  logic [3:0]           cnt;
  logic                 clr_q, rep_entry;
  logic [NUM_SLOTS-1:0] slot_en, hit_now;
`ifdef STRING_MATCH_HITCNT_EN
  logic [NUM_SLOTS-1:0] len_wr;
  logic [15:0]          hc [NUM_SLOTS];
  logic [15:0]          hc_sel;
`endif
  string_slot_regs #(.NUM_SLOTS(NUM_SLOTS)) u_regs (
    .clk(clk),
    .rst(rst),
    .prog_we(prog_we),
    .prog_ready(prog_ready),
    .prog_slot(prog_slot),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .prog_err(prog_err),
    .cmp_flagged_string(cmp_flagged_string),
    .cmp_strlen(cmp_strlen),
    .slot_en(slot_en)
`ifdef STRING_MATCH_HITCNT_EN
    ,
    .len_wr(len_wr)
`endif
  );
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb
    nxt = state == IDLE   ? (frame_start ? (frame_end ? DRAIN : SCAN) : IDLE) :
          state == SCAN   ? (frame_end ? DRAIN : SCAN) :
          state == DRAIN  ? (cnt == 4'd0 ? REPORT : DRAIN) :
          state == REPORT ? (result_ack ? CLEAR : REPORT) : IDLE;
  always_comb begin
    prog_ready   = state == IDLE;
    result_valid = state == REPORT;
    cmp_clear    = clr_q || state == CLEAR;
    result_hit   = |result_mask;
    hit_now      = cmp_match & slot_en;
    rep_entry    = state == DRAIN && cnt == 4'd0;
  end
  always_ff @(posedge clk) begin
    clr_q       <= rst;
    cnt         <= (rst || state != DRAIN) ? 4'(DRAIN_CYCLES - 1) : cnt - 4'd1;
    result_mask <= rst ? '0 : rep_entry ? hit_now : result_mask;
    drop_cnt    <= rst ? '0 : (frame_start && state != IDLE && drop_cnt != 8'hff) ? drop_cnt + 8'd1 : drop_cnt;
  end
`ifdef STRING_MATCH_HITCNT_EN
  always_comb begin
    hc_sel = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (hitcnt_sel == 3'(i)) hc_sel = hc[i];
  end
  always_ff @(posedge clk) begin
    hitcnt_data <= rst ? '0 : hc_sel;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (rst || len_wr[i]) hc[i] <= '0;
      else if (rep_entry && hit_now[i] && hc[i] != 16'hffff) hc[i] <= hc[i] + 16'd1;
  end
`endif
endmodule

// File: tb/tb_string_match_ctrl.sv
// tb_string_match_ctrl: randomized self-checking bench against a frame-level reference model
module tb_string_match_ctrl;
  localparam int NS = 4;
  localparam int D  = 2;
  logic            clk = 0;
  logic            rst, prog_we, frame_start, frame_end, result_ack;
  logic [2:0]      prog_slot;
  logic [4:0]      prog_addr;
  logic [7:0]      prog_data;
  logic            prog_ready, prog_err, cmp_clear, result_valid, result_hit;
  logic [NS*136-1:0] cmp_flagged_string;
  logic [NS*5-1:0] cmp_strlen;
  logic [NS-1:0]   cmp_match, result_mask;
  logic [7:0]      drop_cnt;
  int              total = 0, bad = 0;
  logic [7:0]      m_str [NS][17];
  logic [4:0]      m_len [NS];
  int              m_drop;
  logic            p_pend = 0, p_ok;
  logic [2:0]      p_s;
  logic [4:0]      p_a;
  logic [7:0]      p_d;
  int              np, nw, h, sel;
  always #5 clk = ~clk;
  string_match_ctrl #(.NUM_SLOTS(NS), .DRAIN_CYCLES(D)) dut (
    .clk(clk),
    .rst(rst),
    .prog_we(prog_we),
    .prog_slot(prog_slot),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .prog_ready(prog_ready),
    .prog_err(prog_err),
    .frame_start(frame_start),
    .frame_end(frame_end),
    .cmp_clear(cmp_clear),
    .cmp_flagged_string(cmp_flagged_string),
    .cmp_strlen(cmp_strlen),
    .cmp_match(cmp_match),
    .result_valid(result_valid),
    .result_hit(result_hit),
    .result_mask(result_mask),
    .result_ack(result_ack),
    .drop_cnt(drop_cnt)
  );
  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [135:0] exp_str(input int s);
    logic [135:0] v;
    for (int i = 0; i < 17; i++) v[(16-i)*8 +: 8] = m_str[s][i];
    return v;
  endfunction
  function automatic logic [NS*5-1:0] exp_lens();
    logic [NS*5-1:0] v;
    for (int s = 0; s < NS; s++) v[s*5 +: 5] = m_len[s];
    return v;
  endfunction
  function automatic logic [NS-1:0] exp_en();
    logic [NS-1:0] v;
    for (int s = 0; s < NS; s++) v[s] = m_len[s] != 0;
    return v;
  endfunction
  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_len[s] = 0;
      for (int i = 0; i < 17; i++) m_str[s][i] = 0;
    end
    m_drop = 0;
  endtask
  task automatic bump();
    if (frame_start && m_drop < 255) m_drop++;
  endtask
  task automatic prog_set(input logic [2:0] s, input logic [4:0] a, input logic [7:0] d, input bit idle);
    prog_we = 1; prog_slot = s; prog_addr = a; prog_data = d;
    p_s = s; p_a = a; p_d = d; p_pend = 1;
    p_ok = idle && s < NS && (a <= 16 || (a == 31 && d[4:0] <= 17));
  endtask
  task automatic prog_post();
    check("prog_err", prog_err, !p_ok);
    if (p_ok) begin
      if (p_a == 31) m_len[p_s] = p_d[4:0];
      else m_str[p_s][p_a] = p_d;
    end
    check("strlen", cmp_strlen, exp_lens());
    if (p_s < NS) check("string", cmp_flagged_string[int'(p_s)*136 +: 136], exp_str(int'(p_s)));
    prog_we = 0; p_pend = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    if (p_pend) prog_post();
  endtask
  task automatic run_frame(input int nw, input logic [NS-1:0] match, input int hold, input int rep_starts, input bit mid_prog, input int stray_pct);
    logic [NS-1:0] em;
    int n;
    em = match & exp_en();
    cmp_match = match;
    frame_start = 1; frame_end = (nw == 1);
    step();
    check("busy_ready", prog_ready, 0);
    for (int w = 1; w < nw; w++) begin
      frame_start = $urandom_range(0, 99) < stray_pct;
      frame_end = (w == nw - 1);
      bump();
      if (mid_prog && w == 1) prog_set(3'd0, 5'd31, 8'd9, 0);
      step();
    end
    frame_end = 0;
    n = 0;
    while (!result_valid && n < 40) begin
      frame_start = $urandom_range(0, 99) < stray_pct;
      bump();
      step();
      n++;
    end
    frame_start = 0;
    check("latency", n, D);
    check("mask", result_mask, em);
    check("hit", result_hit, |em);
    for (int i = 0; i < hold; i++) begin
      frame_start = i < rep_starts;
      bump();
      step();
      check("hold_valid", result_valid, 1);
      check("hold_mask", result_mask, em);
    end
    frame_start = 0; result_ack = 1;
    step();
    result_ack = 0;
    check("clear_on", cmp_clear, 1);
    check("clear_valid", result_valid, 0);
    step();
    check("clear_off", cmp_clear, 0);
    check("idle_ready", prog_ready, 1);
    check("drop", drop_cnt, m_drop);
    cmp_match = 0;
    step();
    check("no_extra", result_valid, 0);
  endtask
  initial begin
    rst = 1; prog_we = 0; frame_start = 0; frame_end = 0; result_ack = 0;
    prog_slot = 0; prog_addr = 0; prog_data = 0; cmp_match = 0;
    model_reset();
    step();
    step();
    rst = 0;
    check("rst_clear", cmp_clear, 1);
    check("rst_ready", prog_ready, 1);
    check("rst_err", prog_err, 0);
    check("rst_valid", result_valid, 0);
    check("rst_hit", result_hit, 0);
    check("rst_mask", result_mask, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_strlen", cmp_strlen, 0);
    step();
    check("rst_clear_off", cmp_clear, 0);
    prog_set(0, 0, "E", 1); step();
    prog_set(0, 1, "V", 1); step();
    prog_set(0, 2, "I", 1); step();
    prog_set(0, 3, "L", 1); step();
    prog_set(0, 31, 4, 1); step();
    run_frame(4, 4'b0001, 0, 0, 0, 0);
    run_frame(2, 4'b0100, 0, 0, 0, 0);
    prog_set(1, 31, 18, 1); step();
    prog_set(5, 0, 8'h41, 1); step();
    prog_set(2, 20, 8'h41, 1); step();
    step();
    check("err_pulse", prog_err, 0);
    run_frame(3, 4'b0011, 0, 0, 1, 0);
    frame_end = 1;
    step();
    frame_end = 0;
    check("lone_end", prog_ready, 1);
    run_frame(1, 4'b0001, 10, 1, 0, 0);
    frame_start = 1; frame_end = 1;
    step();
    frame_start = 0; frame_end = 0; rst = 1;
    step();
    rst = 0;
    model_reset();
    check("drain_rst_valid", result_valid, 0);
    check("drain_rst_clear", cmp_clear, 1);
    check("drain_rst_ready", prog_ready, 1);
    check("drain_rst_strlen", cmp_strlen, 0);
    step();
    check("drain_rst_clear_off", cmp_clear, 0);
    step();
    check("drain_rst_no_verdict", result_valid, 0);
    for (int it = 0; it < 25; it++) begin
      np = $urandom_range(0, 4);
      for (int k = 0; k < np; k++) begin
        sel = $urandom_range(0, 9);
        if (sel < 6) prog_set(3'($urandom_range(0, 5)), 5'($urandom_range(0, 16)), 8'($urandom), 1);
        else if (sel < 8) prog_set(3'($urandom_range(0, 5)), 5'd31, {3'($urandom), 5'($urandom_range(0, 20))}, 1);
        else prog_set(3'($urandom_range(0, 5)), 5'($urandom_range(17, 30)), 8'($urandom), 1);
        step();
      end
      nw = $urandom_range(1, 4);
      h = $urandom_range(0, 4);
      run_frame(nw, 4'($urandom), h, $urandom_range(0, h), 1'($urandom_range(0, 1)), 30);
    end
    run_frame(2, 4'b1111, 270, 270, 0, 50);
    check("drop_sat", drop_cnt, 255);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
